// File: rtl/dll_tx_scheduler.sv
// Packet-atomic DLL TX scheduler: Ack/Nak DLLP > replay > round-robin new TLPs onto one registered AXIS stream.
// Optional macro DLL_TX_DLLP_CRC_EN: compute the DLLP CRC-16 internally, otherwise the CRC bytes are zero.
module dll_tx_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH/8,
    parameter int USER_WIDTH = 1,
    parameter int S_COUNT    = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    input  logic [S_COUNT-1:0]            s_axis_tlast,
    input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
    output logic [S_COUNT-1:0]            s_axis_tready,
    input  logic [DATA_WIDTH-1:0]         s_axis_retry_tdata,
    input  logic [KEEP_WIDTH-1:0]         s_axis_retry_tkeep,
    input  logic                          s_axis_retry_tvalid,
    input  logic                          s_axis_retry_tlast,
    input  logic [USER_WIDTH-1:0]         s_axis_retry_tuser,
    output logic                          s_axis_retry_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    output logic [USER_WIDTH-1:0]         m_axis_tuser,
    input  logic                          m_axis_tready,
    input  logic                          ack_nack_i,
    input  logic                          ack_nack_vld_i,
    input  logic [11:0]                   ack_seq_num_i,
    output logic [CNT_WIDTH-1:0]          tlp_count_o,
    output logic [CNT_WIDTH-1:0]          replay_count_o,
    output logic [CNT_WIDTH-1:0]          dllp_count_o
);
    localparam int RR_W = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;
    localparam bit DW64 = (DATA_WIDTH == 64);

    typedef enum logic [1:0] {IDLE, DLLP, RETRY, TLP} state_t;

    state_t                 state_q;
    logic [RR_W-1:0]        rr_q, grant_q;
    logic                   pend_vld_q, pend_nak_q;
    logic [11:0]            pend_seq_q;
    logic                   dllp_nak_q, dllp_beat_q;
    logic [11:0]            dllp_seq_q;
    logic                   m_valid_q, m_last_q;
    logic [DATA_WIDTH-1:0]  m_data_q;
    logic [KEEP_WIDTH-1:0]  m_keep_q;
    logic [USER_WIDTH-1:0]  m_user_q;
    logic [CNT_WIDTH-1:0]   tlp_cnt_q, replay_cnt_q, dllp_cnt_q;

    logic accept;
    assign accept = !m_valid_q || m_axis_tready;

    assign s_axis_tready       = (state_q == TLP && accept) ? (S_COUNT'(1) << grant_q) : '0;
    assign s_axis_retry_tready = (state_q == RETRY) && accept;

    logic                  src_valid, src_last;
    logic [DATA_WIDTH-1:0] src_data;
    logic [KEEP_WIDTH-1:0] src_keep;
    logic [USER_WIDTH-1:0] src_user;

    always_comb begin
        if (state_q == RETRY) begin
            src_valid = s_axis_retry_tvalid;
            src_last  = s_axis_retry_tlast;
            src_data  = s_axis_retry_tdata;
            src_keep  = s_axis_retry_tkeep;
            src_user  = s_axis_retry_tuser;
        end else begin
            src_valid = s_axis_tvalid[grant_q];
            src_last  = s_axis_tlast[grant_q];
            src_data  = s_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
            src_keep  = s_axis_tkeep[int'(grant_q)*KEEP_WIDTH +: KEEP_WIDTH];
            src_user  = s_axis_tuser[int'(grant_q)*USER_WIDTH +: USER_WIDTH];
        end
    end

    // First requesting channel at or after the round-robin pointer, wrapping.
    logic            rr_found;
    logic [RR_W-1:0] rr_pick, rr_next;
    int              rr_idx;

    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        rr_idx   = 0;
        for (int i = 0; i < S_COUNT; i++) begin
            rr_idx = int'(rr_q) + i;
            if (rr_idx >= S_COUNT) rr_idx = rr_idx - S_COUNT;
            if (!rr_found && s_axis_tvalid[rr_idx]) begin
                rr_found = 1'b1;
                rr_pick  = RR_W'(rr_idx);
            end
        end
        rr_next = (rr_pick == RR_W'(S_COUNT - 1)) ? '0 : rr_pick + RR_W'(1);
    end

    // A new request may not downgrade a pending NAK to an ACK.
    logic pend_load;
    assign pend_load = ack_nack_vld_i && (!pend_vld_q || !ack_nack_i || !pend_nak_q);

    logic [7:0]  dllp_b0, dllp_b2, dllp_b3;
    logic [15:0] dllp_crc;
    logic [47:0] dllp_bytes;

    assign dllp_b0 = dllp_nak_q ? 8'h10 : 8'h00;
    assign dllp_b2 = {4'h0, dllp_seq_q[11:8]};
    assign dllp_b3 = dllp_seq_q[7:0];

`ifdef DLL_TX_DLLP_CRC_EN
    function automatic logic [7:0] bit_rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // Message bits enter LSB-first starting at byte 0; result is inverted and bit-reversed per byte.
    function automatic logic [15:0] crc16_dllp(input logic [31:0] msg);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < 32; i++)
            c = {c[14:0], 1'b0} ^ ((c[15] ^ msg[i]) ? 16'h100B : 16'h0000);
        c = ~c;
        return {bit_rev8(c[15:8]), bit_rev8(c[7:0])};
    endfunction

    assign dllp_crc = crc16_dllp({dllp_b3, dllp_b2, 8'h00, dllp_b0});
`else
    assign dllp_crc = 16'h0000;
`endif

    assign dllp_bytes = {dllp_crc[7:0], dllp_crc[15:8], dllp_b3, dllp_b2, 8'h00, dllp_b0};

    logic [DATA_WIDTH-1:0] dllp_data;
    logic [KEEP_WIDTH-1:0] dllp_keep;
    logic                  dllp_last;

    always_comb begin
        if (DW64) begin
            dllp_data = DATA_WIDTH'(dllp_bytes);
            dllp_keep = KEEP_WIDTH'(8'h3F);
            dllp_last = 1'b1;
        end else if (!dllp_beat_q) begin
            dllp_data = DATA_WIDTH'(dllp_bytes[31:0]);
            dllp_keep = KEEP_WIDTH'(4'hF);
            dllp_last = 1'b0;
        end else begin
            dllp_data = DATA_WIDTH'(dllp_bytes[47:32]);
            dllp_keep = KEEP_WIDTH'(4'h3);
            dllp_last = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            rr_q         <= '0;
            grant_q      <= '0;
            pend_vld_q   <= 1'b0;
            pend_nak_q   <= 1'b0;
            pend_seq_q   <= '0;
            dllp_nak_q   <= 1'b0;
            dllp_seq_q   <= '0;
            dllp_beat_q  <= 1'b0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            m_data_q     <= '0;
            m_keep_q     <= '0;
            m_user_q     <= '0;
            tlp_cnt_q    <= '0;
            replay_cnt_q <= '0;
            dllp_cnt_q   <= '0;
        end else begin
            // The granted DLLP leaves the latch; a same-cycle strobe becomes the next pending one.
            if (state_q == IDLE && pend_vld_q) begin
                pend_vld_q <= ack_nack_vld_i;
                if (ack_nack_vld_i) begin
                    pend_nak_q <= !ack_nack_i;
                    pend_seq_q <= ack_seq_num_i;
                end
            end else if (pend_load) begin
                pend_vld_q <= 1'b1;
                pend_nak_q <= !ack_nack_i;
                pend_seq_q <= ack_seq_num_i;
            end

            case (state_q)
                IDLE: begin
                    if (accept) m_valid_q <= 1'b0;
                    if (pend_vld_q) begin
                        state_q     <= DLLP;
                        dllp_nak_q  <= pend_nak_q;
                        dllp_seq_q  <= pend_seq_q;
                        dllp_beat_q <= 1'b0;
                    end else if (s_axis_retry_tvalid) begin
                        state_q <= RETRY;
                    end else if (rr_found) begin
                        state_q <= TLP;
                        grant_q <= rr_pick;
                        rr_q    <= rr_next;
                    end
                end
                DLLP: begin
                    if (accept) begin
                        m_valid_q <= 1'b1;
                        m_data_q  <= dllp_data;
                        m_keep_q  <= dllp_keep;
                        m_last_q  <= dllp_last;
                        m_user_q  <= '0;
                        if (dllp_last) begin
                            state_q    <= IDLE;
                            dllp_cnt_q <= dllp_cnt_q + CNT_WIDTH'(1);
                        end else begin
                            dllp_beat_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (accept) begin
                        m_valid_q <= src_valid;
                        if (src_valid) begin
                            m_data_q <= src_data;
                            m_keep_q <= src_keep;
                            m_last_q <= src_last;
                            m_user_q <= src_user;
                            if (src_last) begin
                                state_q <= IDLE;
                                if (state_q == RETRY) replay_cnt_q <= replay_cnt_q + CNT_WIDTH'(1);
                                else                  tlp_cnt_q    <= tlp_cnt_q + CNT_WIDTH'(1);
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign m_axis_tvalid  = m_valid_q;
    assign m_axis_tdata   = m_data_q;
    assign m_axis_tkeep   = m_keep_q;
    assign m_axis_tlast   = m_last_q;
    assign m_axis_tuser   = m_user_q;
    assign tlp_count_o    = tlp_cnt_q;
    assign replay_count_o = replay_cnt_q;
    assign dllp_count_o   = dllp_cnt_q;

endmodule
